// File: rtl/frequency_reader_pkg.sv
// ============================================================================
// frequency_reader_pkg : shared FSM encoding and AXI constants for the reader
// Revision 1.0
// ============================================================================
`default_nettype none

package frequency_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam int         REGISTER_STRIDE = 4;
  localparam int         RESULT_W        = 32;
  localparam int         INDEX_W         = 3;

endpackage

`default_nettype wire

// File: rtl/frequency_reader_axi_rd.sv
// ============================================================================
// frequency_reader_axi_rd : AR/R handshake engine for one AXI4-Lite read
// Revision 1.0
// ============================================================================
`default_nettype none

module frequency_reader_axi_rd
  import frequency_reader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic              ar_hs_o,
  output logic              r_hs_o
);

  logic [ADDR_W-1:0] araddr_q;
  logic              arvalid_q;
  logic              rready_q;

  // rready rises on the same edge the address is accepted, so no idle cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else if (start_i) begin
      araddr_q  <= addr_i;
      arvalid_q <= 1'b1;
    end else if (arvalid_q && arready_i) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b1;
    end else if (rready_q && rvalid_i) begin
      rready_q  <= 1'b0;
    end
  end

  assign araddr_o  = araddr_q;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;
  assign ar_hs_o   = arvalid_q && arready_i;
  assign r_hs_o    = rready_q && rvalid_i;

endmodule

`default_nettype wire

// File: rtl/frequency_result_reader.sv
// ============================================================================
// frequency_result_reader : on irq rising edge, reads result registers over
// AXI4-Lite and streams them out. Define FREQUENCY_READER_THRESHOLD_EN for
// the detected[6:0] threshold vector.  Revision 1.0
// ============================================================================
`default_nettype none

module frequency_result_reader
  import frequency_reader_pkg::*;
#(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 10,
  parameter int BASE_ADDRESS         = 0,
  parameter int REGISTERS_NUMBER     = 6,
  parameter int MIN_ACTION_TIME      = 1000
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_aresetn,
  input  logic                            irq,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic [2:0]                      m00_axi_arprot,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0]                      m00_axi_rresp,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready,
  output logic [RESULT_W-1:0]             result_data,
  output logic [INDEX_W-1:0]              result_index,
  output logic                            result_last,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            error
`ifdef FREQUENCY_READER_THRESHOLD_EN
  ,
  output logic [6:0]                      detected
`endif
);

  generate
    if (REGISTERS_NUMBER < 1 || REGISTERS_NUMBER > 7 || MIN_ACTION_TIME < 0) begin : g_bad_param
      $error("frequency_result_reader: REGISTERS_NUMBER must be 1..7");
    end
  endgenerate

  state_e                    state_q;
  logic                      irq_q;
  logic [INDEX_W-1:0]        idx_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      error_q;
  logic                      res_valid_q;
  logic [RESULT_W-1:0]       res_data_q;
  logic [INDEX_W-1:0]        res_index_q;
  logic                      res_last_q;

  logic                      irq_rise;
  logic                      launch;
  logic                      ar_hs;
  logic                      r_hs;
  logic [INDEX_W-1:0]        idx_d;
  logic [C_M00_AXI_ADDR_WIDTH-1:0] araddr_d;
  logic [RESULT_W-1:0]       rdata_w;

  assign irq_rise = irq && !irq_q;
  assign launch   = (state_q == ST_IDLE && irq_rise) ||
                    (state_q == ST_OUT && result_ready && !res_last_q);
  assign idx_d    = (state_q == ST_IDLE) ? INDEX_W'(1) : idx_q + INDEX_W'(1);
  assign araddr_d = C_M00_AXI_ADDR_WIDTH'(BASE_ADDRESS + REGISTER_STRIDE * int'(idx_d));
  assign rdata_w  = RESULT_W'(m00_axi_rdata);

  frequency_reader_axi_rd #(
    .ADDR_W (C_M00_AXI_ADDR_WIDTH)
  ) u_axi_rd (
    .clk_i     (m00_axi_aclk),
    .rst_ni    (m00_axi_aresetn),
    .start_i   (launch),
    .addr_i    (araddr_d),
    .araddr_o  (m00_axi_araddr),
    .arvalid_o (m00_axi_arvalid),
    .arready_i (m00_axi_arready),
    .rvalid_i  (m00_axi_rvalid),
    .rready_o  (m00_axi_rready),
    .ar_hs_o   (ar_hs),
    .r_hs_o    (r_hs)
  );

  // irq_q resets high so a level already present at release is not an edge
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q     <= ST_IDLE;
      irq_q       <= 1'b1;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
      res_last_q  <= 1'b0;
    end else begin
      irq_q  <= irq;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (irq_rise) begin
            state_q <= ST_ADDR;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            idx_q   <= idx_d;
          end
        end
        ST_ADDR: begin
          if (ar_hs) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (r_hs) begin
            state_q     <= ST_OUT;
            res_valid_q <= 1'b1;
            res_data_q  <= rdata_w;
            res_index_q <= idx_q;
            res_last_q  <= (idx_q == INDEX_W'(REGISTERS_NUMBER));
            if (m00_axi_rresp != RESP_OKAY) error_q <= 1'b1;
          end
        end
        ST_OUT: begin
          if (result_ready) begin
            res_valid_q <= 1'b0;
            if (res_last_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_ADDR;
              idx_q   <= idx_d;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FREQUENCY_READER_THRESHOLD_EN
  logic [6:0] detected_q;

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      detected_q <= '0;
    end else if (state_q == ST_IDLE && irq_rise) begin
      detected_q <= '0;
    end else if (state_q == ST_DATA && r_hs && rdata_w >= RESULT_W'(MIN_ACTION_TIME)) begin
      detected_q[idx_q - INDEX_W'(1)] <= 1'b1;
    end
  end

  assign detected = detected_q;
`endif

  assign m00_axi_arprot = 3'b000;
  assign result_data    = res_data_q;
  assign result_index   = res_index_q;
  assign result_last    = res_last_q;
  assign result_valid   = res_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

`default_nettype wire

// File: tb/tb_frequency_result_reader.sv
// ============================================================================
// tb_frequency_result_reader : randomized AXI responder plus scoreboard bench
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_frequency_result_reader;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int BASE = 0;
  localparam int R    = 6;
`ifdef FREQUENCY_READER_THRESHOLD_EN
  localparam int MIN_T = 250;
`else
  localparam int MIN_T = 1000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          irq;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [31:0]   result_data;
  logic [2:0]    result_index;
  logic          result_last;
  logic          result_valid;
  logic          result_ready;
  logic          busy;
  logic          done;
  logic          error;
`ifdef FREQUENCY_READER_THRESHOLD_EN
  logic [6:0]    detected;
`endif

  always #5 clk = ~clk;

  frequency_result_reader #(
    .C_M00_AXI_DATA_WIDTH (DW),
    .C_M00_AXI_ADDR_WIDTH (AW),
    .BASE_ADDRESS         (BASE),
    .REGISTERS_NUMBER     (R),
    .MIN_ACTION_TIME      (MIN_T)
  ) dut (
    .m00_axi_aclk    (clk),
    .m00_axi_aresetn (rst_n),
    .irq             (irq),
    .m00_axi_araddr  (araddr),
    .m00_axi_arprot  (arprot),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_rdata   (rdata),
    .m00_axi_rresp   (rresp),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready),
    .result_data     (result_data),
    .result_index    (result_index),
    .result_last     (result_last),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .busy            (busy),
    .done            (done),
    .error           (error)
`ifdef FREQUENCY_READER_THRESHOLD_EN
    ,
    .detected        (detected)
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          last;
  } res_t;

  res_t        exp_res_q[$];
  int          exp_addr_q[$];
  bit          exp_err_q[$];
`ifdef FREQUENCY_READER_THRESHOLD_EN
  logic [6:0]  exp_det_q[$];
`endif

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;
  int err_reg = 0;
  int stall_idx = 0;
  int stall_left = 0;
  int fixed_ar = 0;
  int fixed_r = 0;
  bit rand_stall = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none at %0t", name, $time);
  endtask

  function automatic int pick(input int fixed_val);
    return (fixed_val < 0) ? int'($urandom_range(0, 3)) : fixed_val;
  endfunction

  task automatic flush_expect();
    exp_res_q.delete();
    exp_addr_q.delete();
    exp_err_q.delete();
`ifdef FREQUENCY_READER_THRESHOLD_EN
    exp_det_q.delete();
`endif
  endtask

  // Reference model: one sweep reads registers 1..R in order and forwards their values.
  task automatic expect_sweep(input bit fixed_data);
`ifdef FREQUENCY_READER_THRESHOLD_EN
    logic [6:0] det = '0;
`endif
    for (int n = 1; n <= R; n++) begin
      mem[n] = fixed_data ? 32'(100 * n) : 32'($urandom_range(0, 2000));
      exp_res_q.push_back('{data: mem[n], idx: n, last: (n == R)});
      exp_addr_q.push_back(BASE + 4 * n);
`ifdef FREQUENCY_READER_THRESHOLD_EN
      if (mem[n] >= 32'(MIN_T)) det[n-1] = 1'b1;
`endif
    end
    exp_err_q.push_back(err_reg >= 1 && err_reg <= R);
`ifdef FREQUENCY_READER_THRESHOLD_EN
    exp_det_q.push_back(det);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_result_data"}, result_data, 0);
    chk({tag, "_result_index"}, result_index, 0);
    chk({tag, "_result_last"}, result_last, 0);
  endtask

  // AXI slave responder; also scoreboards AR addresses and single-outstanding rule
  initial begin : responder
    bit            pend;
    bit            armed;
    bit            p_arvalid;
    bit            p_rready;
    logic [AW-1:0] p_araddr;
    int            ar_cnt;
    int            r_cnt;
    int            pidx;
    pend = 0; armed = 0; p_arvalid = 0; p_rready = 0; p_araddr = '0;
    ar_cnt = 0; r_cnt = 0; pidx = 0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; armed = 0; p_arvalid = 0; p_rready = 0;
        arready = 1'b0; rvalid = 1'b0;
        continue;
      end
      if (p_arvalid && arready) begin
        chk("single_outstanding", pend, 0);
        if (exp_addr_q.size() == 0) fail("unexpected_ar");
        else chk("araddr", p_araddr, 64'(exp_addr_q.pop_front()));
        pidx = (int'(p_araddr) - BASE) / 4;
        if (pidx < 0 || pidx > 15) pidx = 0;
        pend = 1; armed = 0;
        r_cnt = pick(fixed_r);
      end else if (p_arvalid) begin
        chk("arvalid_held", arvalid, 1);
        chk("araddr_held", araddr, p_araddr);
      end
      if (p_rready && rvalid) begin
        pend = 0;
        rvalid = 1'b0;
      end
      arready = 1'b0;
      if (arvalid) begin
        if (!armed) begin ar_cnt = pick(fixed_ar); armed = 1; end
        if (ar_cnt == 0) arready = 1'b1;
        else ar_cnt--;
      end
      if (pend && !rvalid) begin
        if (r_cnt == 0) begin
          rvalid = 1'b1;
          rdata  = mem[pidx];
          rresp  = (pidx == err_reg) ? 2'b10 : 2'b00;
        end else r_cnt--;
      end
      p_arvalid = arvalid;
      p_araddr  = araddr;
      p_rready  = rready;
    end
  end

  // Result stream consumer and result scoreboard
  initial begin : consumer
    bit          p_valid;
    bit          p_ready;
    logic [31:0] p_data;
    logic [2:0]  p_index;
    res_t        e;
    p_valid = 0; p_ready = 0; p_data = '0; p_index = '0;
    result_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        result_ready = 1'b1;
        p_valid = 0; p_ready = 0;
        continue;
      end
      if (p_valid && !p_ready) begin
        chk("stall_valid_held", result_valid, 1);
        chk("stall_data_held", result_data, p_data);
        chk("stall_index_held", result_index, p_index);
        chk("no_ar_during_stall", arvalid, 0);
      end
      if (result_valid) begin
        if (stall_left > 0 && int'(result_index) == stall_idx) begin
          result_ready = 1'b0;
          stall_left--;
        end else if (rand_stall && $urandom_range(0, 3) == 0) result_ready = 1'b0;
        else result_ready = 1'b1;
        if (result_ready) begin
          if (exp_res_q.size() == 0) fail("unexpected_result");
          else begin
            e = exp_res_q.pop_front();
            chk("result_data", result_data, e.data);
            chk("result_index", result_index, 64'(e.idx));
            chk("result_last", result_last, e.last);
          end
        end
      end else result_ready = 1'($urandom_range(0, 1));
      p_valid = result_valid;
      p_ready = result_ready;
      p_data  = result_data;
      p_index = result_index;
    end
  end

  initial begin : done_monitor
    bit p_done;
    p_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_done = 0;
        continue;
      end
      if (done) begin
        done_count++;
        chk("done_one_cycle", p_done, 0);
        if (exp_err_q.size() == 0) fail("unexpected_done");
        else chk("error_at_done", error, exp_err_q.pop_front());
`ifdef FREQUENCY_READER_THRESHOLD_EN
        if (exp_det_q.size() != 0) chk("detected_at_done", detected, exp_det_q.pop_front());
`endif
        chk("results_drained", exp_res_q.size(), 0);
        chk("arprot", arprot, 0);
      end
      p_done = done;
    end
  end

  task automatic run_sweep(input bit fixed_data, input bit poke);
    int start;
    bit seen;
    expect_sweep(fixed_data);
    start = done_count;
    irq = 1'b0;
    @(negedge clk);
    irq = 1'b1;
    @(negedge clk);
    chk("busy_after_edge", busy, 1);
    chk("error_clear_at_start", error, 0);
    if (poke) begin
      repeat (4) @(negedge clk);
      irq = 1'b0;
      @(negedge clk);
      irq = 1'b1;
    end
    for (int i = 0; i < 4000 && done_count == start; i++) @(negedge clk);
    if (done_count == start) begin
      fail("sweep_timeout");
      flush_expect();
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | busy | arvalid | result_valid;
    end
    chk("idle_after_done", seen, 0);
    chk("done_pulses", done_count - start, 1);
  endtask

  task automatic reset_mid_sweep();
    bit reached;
    bit seen;
    fixed_r = 20;
    expect_sweep(1'b1);
    irq = 1'b0;
    @(negedge clk);
    irq = 1'b1;
    reached = 0;
    for (int i = 0; i < 400 && !reached; i++) begin
      @(negedge clk);
      reached = rready && (int'(araddr) == BASE + 8);
    end
    if (!reached) fail("reach_data_reg2_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    flush_expect();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fixed_r = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | busy | arvalid;
    end
    chk("no_sweep_on_held_irq", seen, 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n = 1'b0;
    irq   = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(1'b1, 1'b0);
    fixed_ar = 3; fixed_r = 5;
    run_sweep(1'b1, 1'b0);
    fixed_ar = 0; fixed_r = 0;
    stall_idx = 3; stall_left = 10;
    run_sweep(1'b1, 1'b0);
    stall_idx = 0;
    err_reg = 4;
    run_sweep(1'b1, 1'b0);
    err_reg = 0;
    run_sweep(1'b1, 1'b0);
    reset_mid_sweep();
    run_sweep(1'b1, 1'b0);
    run_sweep(1'b0, 1'b1);
    rand_stall = 1; fixed_ar = -1; fixed_r = -1;
    repeat (8) begin
      err_reg = int'($urandom_range(0, 6));
      run_sweep(1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
